// File: rtl/host_cfg_sequencer_pkg.sv
// Shared encodings for host_cfg_sequencer: entry kinds, FSM states and the
// bit offsets of the entry fields that sit above the inst field.
package host_cfg_sequencer_pkg;

  localparam logic [1:0] KIND_PE  = 2'd0;
  localparam logic [1:0] KIND_LSU = 2'd1;
  localparam logic [1:0] KIND_SPM = 2'd2;
  localparam logic [1:0] KIND_NOP = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    GAP,
    DATA,
    RUN,
    DONE
  } state_t;

  // Entry layout is {kind, row, pe, inst}; offsets are relative to INST_W.
  localparam int PE_OFS     = 0;
  localparam int ROW_OFS    = 2;
  localparam int KIND_OFS   = 4;
  localparam int SPM_INST_W = 24;

endpackage

// File: rtl/host_cfg_sequencer_table.sv
// host_cfg_table: configuration entry store with one write port and a
// combinational read port. Contents are deliberately not reset.
module host_cfg_table #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 54
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/host_cfg_sequencer.sv
// host_cfg_sequencer: replays the config table with fixed hold timing, streams
// SPM writes, then pulses run. Define HOST_SEQ_MULTIRUN_EN for run_cnt/run_gap.
module host_cfg_sequencer
  import host_cfg_sequencer_pkg::*;
#(
  parameter int INST_W    = 48,
  parameter int A_W       = 10,
  parameter int DATA_W    = 32,
  parameter int CFG_DEPTH = 16,
  parameter int HOLD      = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(CFG_DEPTH)-1:0] cfg_waddr,
  input  logic [INST_W+5:0]            cfg_wdata,
  input  logic [$clog2(CFG_DEPTH):0]   cfg_num,
  input  logic                         start,
  input  logic [A_W:0]                 data_num,
  input  logic [A_W-1:0]               data_base,
  input  logic                         d_valid,
  input  logic [DATA_W-1:0]            d_data,
`ifdef HOST_SEQ_MULTIRUN_EN
  input  logic [7:0]                   run_cnt,
  input  logic [7:0]                   run_gap,
`endif
  output logic                         d_ready,
  output logic [3:0]                   init_row,
  output logic [3:0]                   init_pe,
  output logic                         init_lsu,
  output logic                         init_spm,
  output logic [INST_W-1:0]            inst,
  output logic                         run,
  output logic                         ex_wen,
  output logic                         ex_ren,
  output logic [A_W-1:0]               ex_addr,
  output logic [DATA_W-1:0]            ex_data,
  output logic                         busy,
  output logic                         done
);

  localparam int PTR_W  = $clog2(CFG_DEPTH);
  localparam int HOLD_W = $clog2(HOLD + 1);

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold;
  logic [A_W:0]        beat;
  logic [PTR_W:0]      ptr_inc;
  logic [A_W:0]        beat_inc;
  logic [PTR_W-1:0]    raddr;
  logic [INST_W+5:0]   entry;
  logic [1:0]          ent_kind, ent_row, ent_pe;
  logic [3:0]          dec_row, dec_pe;
  logic                dec_lsu, dec_spm;
  logic [INST_W-1:0]   dec_inst;

`ifdef HOST_SEQ_MULTIRUN_EN
  logic [7:0] pulses_left, gap_cnt, first_left;
  assign first_left = (run_cnt == 8'd0) ? 8'd0 : run_cnt - 8'd1;
`endif

  assign ex_ren   = 1'b0;
  assign ptr_inc  = {1'b0, ptr} + (PTR_W+1)'(1);
  assign beat_inc = beat + (A_W+1)'(1);
  // Look ahead one entry so the next word is ready on the edge that switches to it.
  assign raddr    = (state == CFG) ? ptr_inc[PTR_W-1:0] : '0;

  host_cfg_table #(.DEPTH(CFG_DEPTH), .WIDTH(INST_W + 6)) u_table (
    .clk   (clk),
    .we    (cfg_we && (state == IDLE)),
    .waddr (cfg_waddr),
    .wdata (cfg_wdata),
    .raddr (raddr),
    .rdata (entry)
  );

  assign ent_kind = entry[INST_W+KIND_OFS +: 2];
  assign ent_row  = entry[INST_W+ROW_OFS +: 2];
  assign ent_pe   = entry[INST_W+PE_OFS +: 2];

  // LSU entries also forward their inst word; SPM entries keep only the low 24 bits.
  always_comb begin
    dec_row  = '0;
    dec_pe   = '0;
    dec_lsu  = 1'b0;
    dec_spm  = 1'b0;
    dec_inst = '0;
    case (ent_kind)
      KIND_PE: begin
        dec_row  = 4'b1000 >> ent_row;
        dec_pe   = 4'b1000 >> ent_pe;
        dec_inst = entry[INST_W-1:0];
      end
      KIND_LSU: begin
        dec_row  = 4'b1000 >> ent_row;
        dec_lsu  = 1'b1;
        dec_inst = entry[INST_W-1:0];
      end
      KIND_SPM: begin
        dec_spm  = 1'b1;
        dec_inst[SPM_INST_W-1:0] = entry[SPM_INST_W-1:0];
      end
      KIND_NOP: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold     <= '0;
      beat     <= '0;
      d_ready  <= 1'b0;
      init_row <= '0;
      init_pe  <= '0;
      init_lsu <= 1'b0;
      init_spm <= 1'b0;
      inst     <= '0;
      run      <= 1'b0;
      ex_wen   <= 1'b0;
      ex_addr  <= '0;
      ex_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef HOST_SEQ_MULTIRUN_EN
      pulses_left <= '0;
      gap_cnt     <= '0;
`endif
    end else begin
      ex_wen <= 1'b0;
      done   <= 1'b0;
`ifdef HOST_SEQ_MULTIRUN_EN
      if (state != RUN) begin
        pulses_left <= first_left;
        gap_cnt     <= '0;
      end
`endif
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            ptr  <= '0;
            hold <= '0;
            beat <= '0;
            if (cfg_num != '0) begin
              state    <= CFG;
              init_row <= dec_row;
              init_pe  <= dec_pe;
              init_lsu <= dec_lsu;
              init_spm <= dec_spm;
              inst     <= dec_inst;
            end else if (data_num != '0) begin
              state   <= DATA;
              d_ready <= 1'b1;
            end else begin
              state <= RUN;
              run   <= 1'b1;
            end
          end
        end
        CFG: begin
          if (hold == HOLD_W'(HOLD - 1)) begin
            hold <= '0;
            if (ptr_inc == cfg_num) begin
              state    <= GAP;
              init_row <= '0;
              init_pe  <= '0;
              init_lsu <= 1'b0;
              init_spm <= 1'b0;
              inst     <= '0;
            end else begin
              ptr      <= ptr_inc[PTR_W-1:0];
              init_row <= dec_row;
              init_pe  <= dec_pe;
              init_lsu <= dec_lsu;
              init_spm <= dec_spm;
              inst     <= dec_inst;
            end
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        GAP: begin
          if (data_num != '0) begin
            state   <= DATA;
            d_ready <= 1'b1;
          end else begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        // d_ready stays low for one cycle after the last beat so run trails the final write.
        DATA: begin
          if (d_ready) begin
            if (d_valid) begin
              ex_wen  <= 1'b1;
              ex_addr <= data_base + beat[A_W-1:0];
              ex_data <= d_data;
              beat    <= beat_inc;
              if (beat_inc == data_num) d_ready <= 1'b0;
            end
          end else begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
`ifdef HOST_SEQ_MULTIRUN_EN
          if (run) begin
            if (pulses_left == 8'd0) begin
              run   <= 1'b0;
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (run_gap == 8'd0) begin
              pulses_left <= pulses_left - 8'd1;
            end else begin
              run     <= 1'b0;
              gap_cnt <= 8'd1;
            end
          end else if (gap_cnt == run_gap) begin
            run         <= 1'b1;
            pulses_left <= pulses_left - 8'd1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
`else
          run   <= 1'b0;
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
